// File: rtl/intrapred_mb_sequencer.sv
// ---------------------------------------------------------------------------------------------
// intrapred_mb_sequencer
//
// Frame-level controller for the intra-prediction datapath. For each macroblock it issues the
// sixteen luma 4x4 sub-blocks one at a time (each waits for its predecessor's mode), then issues
// the luma 16x16 and both chroma paths together. It collects the chosen modes and presents one
// packed mode record per macroblock on a valid/ready handshake.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   start_i, num_mbs_i       frame start request and macroblock count (latched on accept)
//   busy_o, done_o           frame in progress, one-cycle end-of-frame pulse
//   mbnumber_o, blkidx_o     current macroblock and luma 4x4 sub-block index to the datapath
//   enable_*_o               one-cycle issue pulses for the luma 4x4, luma 16x16 and chroma paths
//   mode_*_i                 saver decisions, sampled on the last cycle of each wait window
//   mb_valid_o, mb_ready_i   mode record handshake
//   mb_modes_luma4x4_o       16 x 3-bit luma 4x4 modes, block k at bits [3k+2:3k]
//   mb_mode_*_o, mb_index_o  luma 16x16 / chroma B / chroma R modes and owning macroblock
// ---------------------------------------------------------------------------------------------
module intrapred_mb_sequencer #(
    parameter int unsigned MB_NUMBER_BITS = 12,
    parameter int unsigned PIPE_LATENCY   = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [MB_NUMBER_BITS:0]   num_mbs_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [MB_NUMBER_BITS:0]   mbnumber_o,
    output logic [3:0]                blkidx_o,
    output logic                      enable_luma4x4_o,
    output logic                      enable_luma16x16_o,
    output logic                      enable_chroma_o,
    input  logic [2:0]                mode_luma4x4_i,
    input  logic [2:0]                mode_luma16x16_i,
    input  logic [2:0]                mode_chromab_i,
    input  logic [2:0]                mode_chromar_i,
    output logic                      mb_valid_o,
    input  logic                      mb_ready_i,
    output logic [47:0]               mb_modes_luma4x4_o,
    output logic [2:0]                mb_mode_luma16x16_o,
    output logic [2:0]                mb_mode_chromab_o,
    output logic [2:0]                mb_mode_chromar_o,
    output logic [MB_NUMBER_BITS:0]   mb_index_o
);

    localparam logic [3:0]              LatLast = 4'(PIPE_LATENCY - 1);
    localparam logic [3:0]              BlkLast = 4'd15;
    localparam logic [MB_NUMBER_BITS:0] MbOne   = {{MB_NUMBER_BITS{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StL4Issue,
        StL4Wait,
        StL16Issue,
        StL16Wait,
        StOut,
        StDone
    } state_e;

    state_e                  state_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    en_l4_q;
    logic                    en_l16_q;
    logic                    en_chroma_q;
    logic                    valid_q;
    logic [MB_NUMBER_BITS:0] mbnum_q;
    logic [MB_NUMBER_BITS:0] num_mbs_q;
    logic [3:0]              blk_q;
    logic [3:0]              lat_q;

    // Working luma 4x4 slots for the macroblock in flight; the published record is only
    // refreshed when the whole macroblock completes, so it never changes while mb_valid is high.
    logic [2:0]              slots_q [16];
    logic [47:0]             slots_packed;

    logic [47:0]             rec_l4_q;
    logic [2:0]              rec_l16_q;
    logic [2:0]              rec_cb_q;
    logic [2:0]              rec_cr_q;
    logic [MB_NUMBER_BITS:0] rec_idx_q;

    logic [MB_NUMBER_BITS:0] last_mb;
    logic                    lat_done;

    // num_mbs_q is non-zero whenever this is consulted, so the subtraction cannot wrap.
    assign last_mb  = num_mbs_q - MbOne;
    assign lat_done = (lat_q == LatLast);

    always_comb begin
        slots_packed = '0;
        for (int k = 0; k < 16; k++) begin
            slots_packed[3*k +: 3] = slots_q[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            en_l4_q     <= 1'b0;
            en_l16_q    <= 1'b0;
            en_chroma_q <= 1'b0;
            valid_q     <= 1'b0;
            mbnum_q     <= '0;
            num_mbs_q   <= '0;
            blk_q       <= '0;
            lat_q       <= '0;
            for (int k = 0; k < 16; k++) begin
                slots_q[k] <= '0;
            end
            rec_l4_q    <= '0;
            rec_l16_q   <= '0;
            rec_cb_q    <= '0;
            rec_cr_q    <= '0;
            rec_idx_q   <= '0;
        end else begin
            // Pulses default low; each is raised only on the transition into its state.
            done_q      <= 1'b0;
            en_l4_q     <= 1'b0;
            en_l16_q    <= 1'b0;
            en_chroma_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        num_mbs_q <= num_mbs_i;
                        mbnum_q   <= '0;
                        blk_q     <= '0;
                        busy_q    <= 1'b1;
                        if (num_mbs_i == '0) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= StL4Issue;
                            en_l4_q <= 1'b1;
                        end
                    end
                end

                StL4Issue: begin
                    lat_q   <= '0;
                    state_q <= StL4Wait;
                end

                StL4Wait: begin
                    if (lat_done) begin
                        slots_q[blk_q] <= mode_luma4x4_i;
                        if (blk_q != BlkLast) begin
                            blk_q   <= blk_q + 4'd1;
                            state_q <= StL4Issue;
                            en_l4_q <= 1'b1;
                        end else begin
                            blk_q       <= '0;
                            state_q     <= StL16Issue;
                            en_l16_q    <= 1'b1;
                            en_chroma_q <= 1'b1;
                        end
                    end else begin
                        lat_q <= lat_q + 4'd1;
                    end
                end

                StL16Issue: begin
                    lat_q   <= '0;
                    state_q <= StL16Wait;
                end

                StL16Wait: begin
                    if (lat_done) begin
                        rec_l4_q  <= slots_packed;
                        rec_l16_q <= mode_luma16x16_i;
                        rec_cb_q  <= mode_chromab_i;
                        rec_cr_q  <= mode_chromar_i;
                        rec_idx_q <= mbnum_q;
                        valid_q   <= 1'b1;
                        state_q   <= StOut;
                    end else begin
                        lat_q <= lat_q + 4'd1;
                    end
                end

                StOut: begin
                    // Nothing is issued until the record is taken: backpressure stalls everything.
                    if (mb_ready_i) begin
                        valid_q <= 1'b0;
                        if (mbnum_q == last_mb) begin
                            state_q <= StDone;
                        end else begin
                            mbnum_q <= mbnum_q + MbOne;
                            blk_q   <= '0;
                            state_q <= StL4Issue;
                            en_l4_q <= 1'b1;
                        end
                    end
                end

                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign mbnumber_o          = mbnum_q;
    assign blkidx_o            = blk_q;
    assign enable_luma4x4_o    = en_l4_q;
    assign enable_luma16x16_o  = en_l16_q;
    assign enable_chroma_o     = en_chroma_q;
    assign mb_valid_o          = valid_q;
    assign mb_modes_luma4x4_o  = rec_l4_q;
    assign mb_mode_luma16x16_o = rec_l16_q;
    assign mb_mode_chromab_o   = rec_cb_q;
    assign mb_mode_chromar_o   = rec_cr_q;
    assign mb_index_o          = rec_idx_q;

endmodule
